uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DBIT, default 8, meaning data bits per frame.
REQ-002 Parameter SB_TICK, default 16, meaning s_tick count for the stop bit (16 = 1 stop bit at 16x oversampling).
REQ-003 clk  input  1  system clock; one clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_tick  input  1  16x-baud enable pulse, one clk wide, from the baud-rate generator.
REQ-006 req0, req1  input  1 each  transmit request from requester 0 and requester 1.
REQ-007 din0, din1  input  DBIT each  frame data from requester 0 and requester 1.
REQ-008 gnt0, gnt1  output  1 each  registered one-cycle grant pulse; marks the cycle in which data was captured.
REQ-009 done0, done1  output  1 each  registered one-cycle pulse to the owner when its frame's stop bit completes.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 tx  output  1  serial line, idle high.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; 4-bit tick counter s, 3-bit bit counter n, DBIT-bit shift register b, 1-bit owner, 1-bit last-served pointer.
REQ-013 IDLE: tx=1, s and n held at 0; if any req is high, the arbiter SHALL select at the next edge, load b with the selected din, set owner, set last = owner, pulse the matching gnt for exactly one cycle, and enter START.
REQ-014 Arbitration: only one req high -> that requester; both high -> the requester not equal to last (round-robin).
REQ-015 Requests outside IDLE SHALL be ignored, never queued; a requester holds req and din stable until it sees gnt.
REQ-016 START: tx=0; on each s_tick, s increments; on s_tick with s==15, s<=0 and state<=DATA.
REQ-017 DATA: tx=b[0] (LSB first); on s_tick with s==15, s<=0 and b<=b>>1; if n==DBIT-1, n<=0 and state<=STOP, else n<=n+1.
REQ-018 STOP: tx=1; on s_tick with s==SB_TICK-1, state<=IDLE, s<=0, and done_owner pulses high for the one cycle following that edge.
REQ-019 Without s_tick, START/DATA/STOP SHALL hold all state; only s_tick advances the frame.
REQ-020 Frame length SHALL be exactly 16 + 16*DBIT + SB_TICK s_ticks from entering START to leaving STOP (160 at defaults).
REQ-021 busy SHALL be high from the gnt cycle through the last STOP cycle and low in the done cycle.
REQ-022 A req held high through done SHALL be arbitrated in that done cycle (IDLE); the next gnt follows one cycle later, so gnt and done never coincide.
REQ-023 gnt0/gnt1 and done0/done1 SHALL each be mutually exclusive.

Reset
REQ-024 On reset low, immediately and asynchronously: state=IDLE, tx=1, busy=0, all gnt and done=0, s=0, n=0, b=0, owner=0, last=1 (requester 0 wins the first contention).
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done pulse; tx returns high at once.
REQ-026 After reset release, the first arbitration occurs at the first clk edge with a req high.

Verification
REQ-027 s_tick every clk, req0=1 with din0=0xA5 -> gnt0 pulses once; tx = 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles; done0 pulses 160 cycles after gnt0; busy low in the done0 cycle.
REQ-028 req0 and req1 both high from reset, held until gnt -> gnt0 first; after done0, gnt1 follows with din1 serialized; then with both high again, gnt0.
REQ-029 req1 asserted while requester 0's frame is in DATA -> no gnt1 until done0; gnt1 exactly one cycle after the done0 cycle.
REQ-030 s_tick held low for 50 clks mid-DATA -> tx, s, n, b frozen; frame resumes and completes with the correct bits.
REQ-031 reset pulsed low during DATA of 0x3C -> tx=1, busy=0 immediately, no done0; a subsequent req0 yields a full, correct frame.
REQ-032 SB_TICK=32, one frame -> STOP high for 32 s_ticks; frame length 176 s_ticks.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : request/grant/done handshake between two requesters
//                      and the arbitrated UART transmitter.
// Revision: 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int DBIT = 8
);
  logic            req0;
  logic            req1;
  logic [DBIT-1:0] din0;
  logic [DBIT-1:0] din1;
  logic            gnt0;
  logic            gnt1;
  logic            done0;
  logic            done1;

  modport master (
    output req0, req1, din0, din1,
    input  gnt0, gnt1, done0, done1
  );

  modport slave (
    input  req0, req1, din0, din1,
    output gnt0, gnt1, done0, done1
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin arbiter for two requesters sharing one UART
//                   transmitter (start bit, DBIT data bits LSB first, stop).
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  uart_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic             tx
);
  // Tick counter widens beyond 4 bits only when the stop bit needs it.
  localparam int c_sw = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int c_nw = (DBIT > 8) ? $clog2(DBIT) : 3;
  localparam logic [c_sw-1:0] c_s_last  = c_sw'(15);
  localparam logic [c_sw-1:0] c_sb_last = c_sw'(SB_TICK - 1);
  localparam logic [c_nw-1:0] c_n_last  = c_nw'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [c_sw-1:0] r_s, w_s_next;
  logic [c_nw-1:0] r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next;
  logic            r_owner, w_owner_next;
  logic            r_last, w_last_next;
  logic            r_gnt0, w_gnt0_next;
  logic            r_gnt1, w_gnt1_next;
  logic            r_done0, w_done0_next;
  logic            r_done1, w_done1_next;
  logic            w_pick1;

  // Requester 1 wins when alone, or on contention when 0 was served last.
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_gnt0  <= w_gnt0_next;
      r_gnt1  <= w_gnt1_next;
      r_done0 <= w_done0_next;
      r_done1 <= w_done1_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_gnt0_next  = 1'b0;
    w_gnt1_next  = 1'b0;
    w_done0_next = 1'b0;
    w_done1_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_s_next = '0;
        w_n_next = '0;
        if (bus.req0 | bus.req1) begin
          w_owner_next = w_pick1;
          w_last_next  = w_pick1;
          w_b_next     = w_pick1 ? bus.din1 : bus.din0;
          w_gnt0_next  = ~w_pick1;
          w_gnt1_next  = w_pick1;
          w_state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == c_s_last) begin
            w_s_next     = '0;
            w_state_next = DATA;
          end else begin
            w_s_next = r_s + c_sw'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == c_s_last) begin
            w_s_next = '0;
            w_b_next = r_b >> 1;
            if (r_n == c_n_last) begin
              w_n_next     = '0;
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + c_nw'(1);
            end
          end else begin
            w_s_next = r_s + c_sw'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s == c_sb_last) begin
            w_s_next     = '0;
            w_state_next = IDLE;
            w_done0_next = ~r_owner;
            w_done1_next = r_owner;
          end else begin
            w_s_next = r_s + c_sw'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_b[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : vector table plus scoreboard of expected frames
//                      (owner, data) checked against the decoded serial line.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int DBIT  = 8;
  localparam int FRAME = 16 + 16 * DBIT + 16;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         n;
    logic       first;
  } vec_t;

  logic clk;
  logic reset;
  logic s_tick;
  logic busy, tx, busy32, tx32;

  uart_tx_arbiter_if #(.DBIT(DBIT)) bus ();
  uart_tx_arbiter_if #(.DBIT(DBIT)) bus32 ();

  uart_tx_arbiter #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus), .busy(busy), .tx(tx)
  );

  uart_tx_arbiter #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus32), .busy(busy32), .tx(tx32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Serial-line monitor: tracks tick position within the current frame.
  int         p = 0;
  logic [7:0] rx = 8'h00;
  bit         tx_bad = 1'b0;
  bit         active = 1'b0;
  bit         prev_active = 1'b0;
  bit         prev_tick = 1'b0;
  bit         prev_gnt = 1'b0;
  logic       prev_tx = 1'b1;

  always @(negedge clk) begin
    logic etx;
    int   bi;
    if (!reset) begin
      active      = 1'b0;
      prev_active = 1'b0;
      prev_gnt    = 1'b0;
      sb.delete();
    end else begin
      check("gnt_exclusive", int'(bus.gnt0 & bus.gnt1), 0);
      check("done_exclusive", int'(bus.done0 & bus.done1), 0);
      check("gnt_done_overlap", int'((bus.gnt0 | bus.gnt1) & (bus.done0 | bus.done1)), 0);
      if (bus.done0 | bus.done1) begin
        check("done_expected", int'(active), 1);
        if (active) begin
          check("done_owner", int'(bus.done1), int'(sb[0].owner));
          check("frame_ticks", p, FRAME);
          check("frame_data", int'(rx), int'(sb[0].data));
          check("frame_waveform", int'(tx_bad), 0);
          void'(sb.pop_front());
          active = 1'b0;
        end
      end
      if (bus.gnt0 | bus.gnt1) begin
        check("gnt_width", int'(prev_gnt), 0);
        check("gnt_while_busy", int'(active), 0);
        check("gnt_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0 && !active) begin
          check("gnt_owner", int'(bus.gnt1), int'(sb[0].owner));
          active = 1'b1;
          p      = 0;
          rx     = 8'h00;
          tx_bad = 1'b0;
        end
      end
      check("busy", int'(busy), int'(active));
      if (active) begin
        if (prev_active && !prev_tick) check("tx_frozen", int'(tx), int'(prev_tx));
        if (p < 16) begin
          etx = 1'b0;
        end else if (p < 16 + 16 * DBIT) begin
          bi  = (p - 16) / 16;
          etx = sb[0].data[bi];
          if ((p % 16) == 8) rx[bi] = tx;
        end else begin
          etx = 1'b1;
        end
        if (tx !== etx) tx_bad = 1'b1;
        if (s_tick) p++;
      end else begin
        check("tx_idle", int'(tx), 1);
      end
      prev_active = active;
      prev_tick   = s_tick;
      prev_tx     = tx;
      prev_gnt    = bus.gnt0 | bus.gnt1;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("frames_complete", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input bit which);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(which ? bus.gnt1 : bus.gnt0) && t < 1000);
    check("gnt_wait", int'(which ? bus.gnt1 : bus.gnt0), 1);
    @(posedge clk); #1;
    if (which) bus.req1 = 1'b0;
    else       bus.req0 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   p0, p1, g0, g1;
    int   t = 0;
    @(posedge clk); #1;
    bus.din0 = v.d0;
    bus.din1 = v.d1;
    bus.req0 = v.r0;
    bus.req1 = v.r1;
    e.owner = v.first;
    e.data  = v.first ? v.d1 : v.d0;
    sb.push_back(e);
    if (v.n == 2) begin
      e.owner = ~v.first;
      e.data  = v.first ? v.d0 : v.d1;
      sb.push_back(e);
    end
    p0 = v.r0;
    p1 = v.r1;
    while ((p0 || p1) && t < 2000) begin
      @(negedge clk);
      t++;
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      @(posedge clk); #1;
      if (g0) begin bus.req0 = 1'b0; p0 = 1'b0; end
      if (g1) begin bus.req1 = 1'b0; p1 = 1'b0; end
    end
    check("all_requests_granted", int'(p0 | p1), 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();
  endtask

  initial begin
    int         t, k, stop_hi;
    logic       txa, start_bit;
    logic [7:0] d32;
    exp_t       e;

    reset = 1'b1;
    s_tick = 1'b1;
    bus.req0 = 1'b0;  bus.req1 = 1'b0;  bus.din0 = '0;  bus.din1 = '0;
    bus32.req0 = 1'b0; bus32.req1 = 1'b0; bus32.din0 = '0; bus32.din1 = '0;

    vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 2, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h81, 8'h7E, 2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h55, 8'h00, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h00, 8'hFF, 2, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h01, 1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1, 1'b0};

    #2 reset = 1'b0;
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_gnt", int'({bus.gnt0, bus.gnt1}), 0);
    check("reset_done", int'({bus.done0, bus.done1}), 0);
    check("reset_tx32", int'(tx32), 1);
    check("reset_busy32", int'(busy32), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Late request from 1 during 0's DATA: served one cycle after done0.
    @(posedge clk); #1;
    bus.din0 = 8'hC3; bus.req0 = 1'b1;
    e.owner = 1'b0; e.data = 8'hC3; sb.push_back(e);
    wait_gnt(1'b0);
    repeat (60) @(posedge clk); #1;
    bus.din1 = 8'h99; bus.req1 = 1'b1;
    e.owner = 1'b1; e.data = 8'h99; sb.push_back(e);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.done0 && t < 1000);
    check("late_done0_seen", int'(bus.done0), 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.gnt1 && k < 1000);
    check("late_gnt1_latency", k, 1);
    @(posedge clk); #1 bus.req1 = 1'b0;
    wait_idle();

    // Baud enable stalled for 50 clocks in the middle of DATA.
    @(posedge clk); #1;
    bus.din0 = 8'h96; bus.req0 = 1'b1;
    e.owner = 1'b0; e.data = 8'h96; sb.push_back(e);
    wait_gnt(1'b0);
    repeat (16 + 16 * 3 + 5) @(posedge clk);
    #1 s_tick = 1'b0;
    @(negedge clk) txa = tx;
    repeat (49) @(negedge clk);
    check("stall_tx_hold", int'(tx), int'(txa));
    check("stall_busy", int'(busy), 1);
    @(posedge clk); #1 s_tick = 1'b1;
    wait_idle();

    // Reset mid-DATA aborts the frame without a done pulse.
    @(posedge clk); #1;
    bus.din0 = 8'h3C; bus.req0 = 1'b1;
    e.owner = 1'b0; e.data = 8'h3C; sb.push_back(e);
    wait_gnt(1'b0);
    repeat (40) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'({bus.done0, bus.done1}), 0);
    check("abort_gnt", int'({bus.gnt0, bus.gnt1}), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (200) @(negedge clk);
    run_vec('{1'b1, 1'b0, 8'h3C, 8'h00, 1, 1'b0});

    // Two-stop-tick-period instance: 32-tick stop bit, 176-tick frame.
    @(posedge clk); #1;
    bus32.din0 = 8'hB4; bus32.req0 = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus32.gnt0 && t < 100);
    check("sb32_gnt", int'(bus32.gnt0), 1);
    bus32.req0 = 1'b0;
    k = 0; stop_hi = 0; start_bit = 1'b1; d32 = 8'h00;
    while (!bus32.done0 && k < 400) begin
      @(negedge clk);
      k++;
      if (!bus32.done0) begin
        if (k == 8) start_bit = tx32;
        if (k >= 24 && k < 152 && ((k - 16) % 16) == 8) d32[(k - 16) / 16] = tx32;
        if (k >= 144 && tx32) stop_hi++;
      end
    end
    check("sb32_busy_in_done", int'(busy32), 0);
    check("sb32_start_bit", int'(start_bit), 0);
    check("sb32_data", int'(d32), 'hB4);
    check("sb32_stop_len", stop_hi, 32);
    check("sb32_frame_len", k, 176);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
